// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field slices,
// fetch FSM states and the default reset vector.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int TGT_HI   = 25;
   localparam int TGT_LO   = 0;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/ifetch_nextpc.sv
// Next-PC calculation: sequential, PC-relative branch and
// region jump, with jump taking priority over a taken branch.
module ifetch_nextpc
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [25:0] tgt_i,
   input  logic        branch_i,
   input  logic        invertzero_i,
   input  logic        jump_i,
   input  logic        zero_i,
   output logic [31:0] pcplus4_o,
   output logic [31:0] next_pc_o
);

   logic [15:0] imm;
   logic [31:0] btarget;
   logic [31:0] jtarget;
   logic        taken;

   // Targets are word-aligned by construction; carries wrap mod 2^32.
   always_comb begin
      pcplus4_o = pc_i + 32'd4;
      imm       = tgt_i[IMM_HI:IMM_LO];
      btarget   = pcplus4_o + {{14{imm[15]}}, imm, 2'b00};
      jtarget   = {pcplus4_o[31:28], tgt_i, 2'b00};
      taken     = branch_i & (zero_i ^ invertzero_i);
      next_pc_o = pcplus4_o;
      if (jump_i)
         next_pc_o = jtarget;
      else if (taken)
         next_pc_o = btarget;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding request, latches the
// word for the decoder and advances the PC on retire.
module ifetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] instr,
   output logic [5:0]      op,
   output logic [5:0]      funct,
   output logic            instr_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcplus4,
   input  logic            retire,
   input  logic            branch,
   input  logic            invertzero,
   input  logic            jump,
   input  logic            zero
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              req_q, req_d;
   logic [XLEN-1:0]   next_pc;
   logic              hs;

   assign hs = req_q & imem_ready;

   ifetch_nextpc u_nextpc (
      .pc_i         (pc_q),
      .tgt_i        (instr_q[TGT_HI:TGT_LO]),
      .branch_i     (branch),
      .invertzero_i (invertzero),
      .jump_i       (jump),
      .zero_i       (zero),
      .pcplus4_o    (pcplus4),
      .next_pc_o    (next_pc)
   );

   // State and datapath registers; reset drops the request at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   // Next state: leave FETCH only on a real handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH: if (hs) state_d = ISSUE;
         ISSUE: if (retire) state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Register updates; request re-arms right after retire.
   always_comb begin
      req_d   = req_q;
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      unique case (state_q)
         FETCH: begin
            req_d = 1'b1;
            if (hs) begin
               req_d   = 1'b0;
               valid_d = 1'b1;
               instr_d = imem_rdata;
            end
         end
         ISSUE: begin
            req_d = 1'b0;
            if (retire) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               req_d   = 1'b1;
            end
         end
         default: begin
            req_d = 1'b0;
         end
      endcase
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[OP_HI:OP_LO];
   assign funct       = instr_q[FUNCT_HI:FUNCT_LO];
   assign instr_valid = valid_q;
   assign pc          = pc_q;

endmodule
